// File: rtl/vdp_pkg.sv
// Shared types and helpers for the lane-parallel dot-product engine.
package vdp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Number of accumulate cycles needed to cover vector_size elements.
  function automatic int steps(input int vector_size, input int lanes);
    return (vector_size + lanes - 1) / lanes;
  endfunction

endpackage

// File: rtl/vdp_lane_sum.sv
// Combinational sum of LANES element-wise products, reduced modulo 2^ACC_WIDTH.
module vdp_lane_sum
  import vdp_pkg::*;
#(
  parameter int LANES      = 1,
  parameter int DATA_WIDTH = 31,
  parameter int ACC_WIDTH  = 65
) (
  input  logic                  signed_mode,
  input  logic [DATA_WIDTH-1:0] a   [LANES],
  input  logic [DATA_WIDTH-1:0] b   [LANES],
  output logic [ACC_WIDTH-1:0]  sum
);

  // Operands are widened at least to ACC_WIDTH so the low ACC_WIDTH product
  // bits are exact for both signed and unsigned interpretation.
  localparam int EXT_WIDTH = (ACC_WIDTH > DATA_WIDTH) ? ACC_WIDTH : DATA_WIDTH;

  function automatic logic [EXT_WIDTH-1:0] extend(input logic [DATA_WIDTH-1:0] x,
                                                  input logic                  sgn);
    logic signed [DATA_WIDTH-1:0] sx;
    sx = x;
    if (sgn) return EXT_WIDTH'(sx);
    return EXT_WIDTH'(x);
  endfunction

  always_comb begin
    // NOTE: the default assignment before the loop keeps this block free of
    // inferred latches; blocking '=' is right here because each iteration
    // builds on the previous partial sum within the same evaluation.
    sum = '0;
    for (int i = 0; i < LANES; i++) begin
      sum = sum + ACC_WIDTH'(extend(a[i], signed_mode) * extend(b[i], signed_mode));
    end
  end

endmodule

// File: rtl/vector_dot_product_lanes.sv
// Multi-cycle dot-product engine: captures two vectors on start, accumulates
// LANES products per cycle, and presents a registered result with a valid pulse.
module vector_dot_product_lanes
  import vdp_pkg::*;
#(
  parameter int VECTOR_SIZE = 4,
  parameter int DATA_WIDTH  = 31,
  parameter int LANES       = 1,
  parameter int ACC_WIDTH   = 2 * DATA_WIDTH + $clog2(VECTOR_SIZE) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  signed_mode,
  input  logic [DATA_WIDTH-1:0] vec1 [0:VECTOR_SIZE-1],
  input  logic [DATA_WIDTH-1:0] vec2 [0:VECTOR_SIZE-1],
  output logic                  busy,
  output logic [ACC_WIDTH-1:0]  result,
  output logic                  valid
);

  localparam int STEPS       = steps(VECTOR_SIZE, LANES);
  localparam int STEP_WIDTH  = $clog2(STEPS + 1);
  localparam int INDEX_WIDTH = (VECTOR_SIZE > 1) ? $clog2(VECTOR_SIZE) : 1;
  localparam logic [STEP_WIDTH-1:0] LAST_STEP = STEP_WIDTH'(STEPS - 1);

  state_t                  state;
  logic [STEP_WIDTH-1:0]   step;
  logic [ACC_WIDTH-1:0]    acc;
  logic [ACC_WIDTH-1:0]    lane_total;
  logic                    accept;

  logic [DATA_WIDTH-1:0]   op_a [0:VECTOR_SIZE-1];
  logic [DATA_WIDTH-1:0]   op_b [0:VECTOR_SIZE-1];
  logic                    op_signed;

  logic [DATA_WIDTH-1:0]   lane_a [LANES];
  logic [DATA_WIDTH-1:0]   lane_b [LANES];

  assign accept = (state == IDLE) && start;

  // NOTE: operand capture registers are deliberately not reset: they are
  // only consumed after a capture, so a reset would just add fan-out.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_a      <= vec1;
      op_b      <= vec2;
      op_signed <= signed_mode;
    end
  end

  // Select this step's operand slice; lanes past the vector end read as zero.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_a[l] = '0;
      lane_b[l] = '0;
      if (int'(step) * LANES + l < VECTOR_SIZE) begin
        lane_a[l] = op_a[INDEX_WIDTH'(int'(step) * LANES + l)];
        lane_b[l] = op_b[INDEX_WIDTH'(int'(step) * LANES + l)];
      end
    end
  end

  vdp_lane_sum #(
    .LANES      (LANES),
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_lane_sum (
    .signed_mode (op_signed),
    .a           (lane_a),
    .b           (lane_b),
    .sum         (lane_total)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      step   <= '0;
      acc    <= '0;
      result <= '0;
      valid  <= 1'b0;
      busy   <= 1'b0;
    end else begin
      valid <= 1'b0;
      unique case (state)
        IDLE: begin
          // busy stays high through the valid cycle and drops in the first idle one
          busy <= accept;
          if (accept) begin
            acc   <= '0;
            step  <= '0;
            state <= ACCUM;
          end
        end
        ACCUM: begin
          acc <= acc + lane_total;
          if (step == LAST_STEP) state <= DONE;
          else                   step  <= step + STEP_WIDTH'(1);
        end
        DONE: begin
          result <= acc;
          valid  <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
